// File: rtl/barrel_shift_pkg.sv
// Shared types and constants for the barrel shifter command path.
package barrel_shift_pkg;

  localparam int DATA_W = 4;
  localparam int SHIFT_W = 2;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // One shift request: operand, amount and direction.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHIFT_W-1:0] shift;
    logic               dir;
  } shift_cmd_t;

  // Controller sequencing around the shifter's one-cycle latency.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// 4-bit registered barrel shifter, zero fill, no reset and no enable.
module barrel_shifter (
  input  logic       clk,
  input  logic [3:0] data,
  input  logic [1:0] shift,
  input  logic       dir,
  output logic [3:0] result
);

  // Shift left (dir=0) or right (dir=1) and register the result.
  always_ff @(posedge clk) begin
    if (dir) result <= data >> shift;
    else     result <= data << shift;
  end

endmodule

// File: rtl/shift_cmd_fifo.sv
// Small synchronous FIFO of shift commands; occupancy count decides full/empty.
module shift_cmd_fifo
  import barrel_shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  shift_cmd_t       push_cmd,
  input  logic             pop,
  output shift_cmd_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  shift_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Requests are ignored when they would overflow or underflow.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Head is read straight from storage so a pop can load it the same cycle.
  assign head = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_cmd;
  end

  // Pointers wrap naturally; count moves by at most one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_ctrl.sv
// Command stage for the registered barrel shifter: buffers requests, issues
// them one at a time and returns each result with its originating command.
module barrel_shift_ctrl
  import barrel_shift_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_data,
  input  logic [1:0]       cmd_shift,
  input  logic             cmd_dir,
  output logic [3:0]       bs_data,
  output logic [1:0]       bs_shift,
  output logic             bs_dir,
  input  logic [3:0]       bs_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [3:0]       rsp_data,
  output logic [1:0]       rsp_shift,
  output logic             rsp_dir,
  output logic [CNT_W-1:0] fifo_count
);

  ctrl_state_t state_reg;
  shift_cmd_t  held_reg;
  shift_cmd_t  push_cmd;
  shift_cmd_t  head_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign push_cmd  = {cmd_data, cmd_shift, cmd_dir};

  shift_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head_cmd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Pop the head when idle, or when the current response is being accepted.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      IDLE:    pop = ~fifo_empty;
      RESP:    pop = rsp_ready & ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Sequencer: issue, wait out the shifter latency, capture, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      held_reg   <= '0;
      bs_data    <= '0;
      bs_shift   <= '0;
      bs_dir     <= DIR_LEFT;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_data   <= '0;
      rsp_shift  <= '0;
      rsp_dir    <= DIR_LEFT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            bs_data   <= head_cmd.data;
            bs_shift  <= head_cmd.shift;
            bs_dir    <= head_cmd.dir;
            held_reg  <= head_cmd;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          rsp_result <= bs_result;
          rsp_data   <= held_reg.data;
          rsp_shift  <= held_reg.shift;
          rsp_dir    <= held_reg.dir;
          rsp_valid  <= 1'b1;
          state_reg  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              bs_data   <= head_cmd.data;
              bs_shift  <= head_cmd.shift;
              bs_dir    <= head_cmd.dir;
              held_reg  <= head_cmd;
              state_reg <= ISSUE;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Self-checking bench for barrel_shift_ctrl driving a real barrel_shifter.
module tb_barrel_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = '0;
  logic [1:0] cmd_shift = '0;
  logic       cmd_dir = 1'b0;
  logic [3:0] bs_data;
  logic [1:0] bs_shift;
  logic       bs_dir;
  logic [3:0] bs_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [3:0] rsp_data;
  logic [1:0] rsp_shift;
  logic       rsp_dir;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  barrel_shift_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_shift  (cmd_shift),
    .cmd_dir    (cmd_dir),
    .bs_data    (bs_data),
    .bs_shift   (bs_shift),
    .bs_dir     (bs_dir),
    .bs_result  (bs_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_data   (rsp_data),
    .rsp_shift  (rsp_shift),
    .rsp_dir    (rsp_dir),
    .fifo_count (fifo_count)
  );

  barrel_shifter u_shifter (
    .clk    (clk),
    .data   (bs_data),
    .shift  (bs_shift),
    .dir    (bs_dir),
    .result (bs_result)
  );

  // Reference: zero-fill shift expressed as multiply/divide by 2**shift.
  function automatic logic [3:0] ref_shift(logic [3:0] d, logic [1:0] s, logic dir);
    int v;
    int p;
    v = int'(d);
    p = 1 << s;
    if (dir) return 4'(v / p);
    return 4'((v * p) % 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
      $display("FAIL reset_ctrl: rsp_valid=%b fifo_count=%0d cmd_ready=%b required 0/0/1",
               rsp_valid, fifo_count, cmd_ready);
      miscompares++;
    end
    vectors++;
    if ({bs_data, bs_shift, bs_dir} !== 7'd0 ||
        {rsp_result, rsp_data, rsp_shift, rsp_dir} !== 11'd0) begin
      $display("FAIL reset_regs: bs=%h rsp=%h required 0/0",
               {bs_data, bs_shift, bs_dir}, {rsp_result, rsp_data, rsp_shift, rsp_dir});
      miscompares++;
    end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_single_left();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 4'b1011; cmd_shift = 2'd1; cmd_dir = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL single_accept: cmd_ready=%b required 1", cmd_ready);
      miscompares++;
    end
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (rsp_valid !== (c == 4)) begin
        $display("FAIL single_latency: cycle %0d rsp_valid=%b required %b", c, rsp_valid, c == 4);
        miscompares++;
      end
      if (c < 4) tick();
    end
    vectors++;
    if (rsp_result !== 4'b0110 || rsp_data !== 4'b1011 || rsp_shift !== 2'd1 ||
        rsp_dir !== 1'b0 || fifo_count !== 3'd0) begin
      $display("FAIL single_rsp: result=%b data=%b shift=%0d dir=%b count=%0d required 0110/1011/1/0/0",
               rsp_result, rsp_data, rsp_shift, rsp_dir, fifo_count);
      miscompares++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL single_drop: rsp_valid=%b required 0", rsp_valid);
      miscompares++;
    end
    $display("single_left: result %b", rsp_result);
  endtask

  task automatic test_right_sweep();
    int sent;
    int got;
    int last;
    logic [3:0] e;
    sent = 0; got = 0; last = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      cmd_valid = (sent < 4);
      cmd_data = 4'b1000; cmd_shift = 2'(sent); cmd_dir = 1'b1;
      if (cmd_valid && cmd_ready) sent++;
      if (rsp_valid) begin
        e = ref_shift(4'b1000, 2'(got), 1'b1);
        vectors++;
        if (rsp_result !== e || rsp_shift !== 2'(got)) begin
          $display("FAIL sweep_rsp: idx %0d result=%b shift=%0d required %b/%0d",
                   got, rsp_result, rsp_shift, e, got);
          miscompares++;
        end
        if (got > 0) begin
          vectors++;
          if (cyc - last != 3) begin
            $display("FAIL sweep_spacing: idx %0d gap=%0d required 3", got, cyc - last);
            miscompares++;
          end
        end
        $display("sweep: shift %0d result %b", got, rsp_result);
        last = cyc;
        got++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    vectors++;
    if (got != 4) begin
      $display("FAIL sweep_count: got %0d responses required 4", got);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] q[$];
    logic [6:0] c;
    logic [3:0] e;
    int accepted;
    int got;
    accepted = 0; got = 0;
    rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cmd_valid = 1'b1;
      cmd_data = 4'($urandom); cmd_shift = 2'($urandom); cmd_dir = 1'($urandom);
      if (cmd_ready) begin
        q.push_back({cmd_data, cmd_shift, cmd_dir});
        accepted++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (accepted != 5) begin
      $display("FAIL bp_accepted: got %0d required 5", accepted);
      miscompares++;
    end
    vectors++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
      $display("FAIL bp_full: cmd_ready=%b fifo_count=%0d required 0/4", cmd_ready, fifo_count);
      miscompares++;
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          vectors++;
          $display("FAIL bp_extra: unexpected response result=%b required none", rsp_result);
          miscompares++;
          break;
        end
        c = q.pop_front();
        e = ref_shift(c[6:3], c[2:1], c[0]);
        vectors++;
        if (rsp_result !== e || {rsp_data, rsp_shift, rsp_dir} !== c) begin
          $display("FAIL bp_rsp: idx %0d result=%b cmd=%h required %b/%h",
                   got, rsp_result, {rsp_data, rsp_shift, rsp_dir}, e, c);
          miscompares++;
        end
        $display("backpressure: rsp %0d result %b", got, rsp_result);
        got++;
        if (got == 1) begin
          tick();
          vectors++;
          if (cmd_ready !== 1'b1 || fifo_count !== 3'd3) begin
            $display("FAIL bp_reassert: cmd_ready=%b fifo_count=%0d required 1/3", cmd_ready, fifo_count);
            miscompares++;
          end
          continue;
        end
      end
      tick();
    end
    rsp_ready = 1'b0;
    vectors++;
    if (got != 5 || fifo_count !== 3'd0) begin
      $display("FAIL bp_drain: got %0d count=%0d required 5/0", got, fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] q[$];
    logic [6:0] c;
    logic [3:0] e;
    logic [2:0] prev_count;
    int sent;
    int got;
    int both_events;
    bit both_now;
    sent = 0; got = 0; both_events = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      cmd_valid = (sent < 8);
      cmd_data = 4'($urandom); cmd_shift = 2'($urandom); cmd_dir = 1'($urandom);
      both_now = cmd_valid && cmd_ready && rsp_valid && (fifo_count != 3'd0);
      prev_count = fifo_count;
      if (cmd_valid && cmd_ready) begin
        q.push_back({cmd_data, cmd_shift, cmd_dir});
        sent++;
      end
      if (rsp_valid) begin
        vectors++;
        if (q.size() == 0) begin
          $display("FAIL simul_extra: unexpected response result=%b required none", rsp_result);
          miscompares++;
          break;
        end
        c = q.pop_front();
        e = ref_shift(c[6:3], c[2:1], c[0]);
        if (rsp_result !== e || {rsp_data, rsp_shift, rsp_dir} !== c) begin
          $display("FAIL simul_rsp: idx %0d result=%b cmd=%h required %b/%h",
                   got, rsp_result, {rsp_data, rsp_shift, rsp_dir}, e, c);
          miscompares++;
        end
        $display("simultaneous: rsp %0d cmd %h result %b", got, c, rsp_result);
        got++;
      end
      tick();
      if (both_now) begin
        both_events++;
        vectors++;
        if (fifo_count !== prev_count) begin
          $display("FAIL simul_count: fifo_count=%0d required %0d", fifo_count, prev_count);
          miscompares++;
        end
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    vectors++;
    if (got != 8 || both_events == 0 || fifo_count !== 3'd0) begin
      $display("FAIL simul_total: got %0d events %0d count %0d required 8/>0/0",
               got, both_events, fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_data = 4'($urandom); cmd_shift = 2'($urandom); cmd_dir = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (fifo_count !== 3'd2 || rsp_valid !== 1'b0) begin
      $display("FAIL mid_pre: fifo_count=%0d rsp_valid=%b required 2/0", fifo_count, rsp_valid);
      miscompares++;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1 ||
        {bs_data, bs_shift, bs_dir} !== 7'd0 || rsp_result !== 4'd0) begin
      $display("FAIL mid_reset: rsp_valid=%b count=%0d ready=%b bs=%h result=%b required 0/0/1/0/0",
               rsp_valid, fifo_count, cmd_ready, {bs_data, bs_shift, bs_dir}, rsp_result);
      miscompares++;
    end
    tick();
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_data = 4'b0001; cmd_shift = 2'd3; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'b1000 || rsp_data !== 4'b0001) begin
      $display("FAIL mid_after: valid=%b result=%b data=%b required 1/1000/0001",
               rsp_valid, rsp_result, rsp_data);
      miscompares++;
    end
    $display("reset_mid: post-reset result %b", rsp_result);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_zero_shift();
    int sent;
    int got;
    sent = 0; got = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
      cmd_valid = (sent < 2);
      cmd_data = 4'b0101; cmd_shift = 2'd0; cmd_dir = 1'(sent);
      if (cmd_valid && cmd_ready) sent++;
      if (rsp_valid) begin
        vectors++;
        if (rsp_result !== ref_shift(4'b0101, 2'd0, 1'(got)) || rsp_result !== 4'b0101 ||
            rsp_dir !== 1'(got)) begin
          $display("FAIL zero_rsp: dir %0d result=%b echo_dir=%b required 0101/%0d",
                   got, rsp_result, rsp_dir, got);
          miscompares++;
        end
        $display("zero_shift: dir %0d result %b", got, rsp_result);
        got++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    vectors++;
    if (got != 2) begin
      $display("FAIL zero_count: got %0d responses required 2", got);
      miscompares++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_left();
    test_right_sweep();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_zero_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
